// File: rtl/instruction_handler.sv
// SPI byte-stream command decoder: 8-byte frames (opcode, 24b address, 32b value) committed atomically.
// Latency 1 cycle from the last byte to commit; no backpressure, every valid byte is accepted.
module instruction_handler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_rx_valid_i,
  input  logic [7:0]  spi_rx_byte_i,
  input  logic [31:0] result_i,
  input  logic [31:0] stream_i,
  output logic [7:0]  instruction_o,
  output logic [23:0] address_o,
  output logic [31:0] value_o,
  output logic [7:0]  spi_tx_byte_o
);

  logic [2:0]  cnt;
  logic [7:0]  opcode_shadow;
  logic [23:0] address_shadow;
  logic [23:0] value_shadow;
  logic [63:0] tx_snapshot;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt            <= 3'd0;
      opcode_shadow  <= 8'h00;
      address_shadow <= 24'h0;
      value_shadow   <= 24'h0;
      tx_snapshot    <= 64'h0;
      instruction_o  <= 8'h00;
      address_o      <= 24'h0;
      value_o        <= 32'h0;
    end else begin
      // Execute strobe lasts exactly one cycle after commit.
      instruction_o <= 8'h00;
      if (spi_rx_valid_i) begin
        cnt <= cnt + 3'd1;
        case (cnt)
          3'd0: begin
            opcode_shadow <= spi_rx_byte_i;
            tx_snapshot   <= {result_i, stream_i};
          end
          3'd1: address_shadow[23:16] <= spi_rx_byte_i;
          3'd2: address_shadow[15:8]  <= spi_rx_byte_i;
          3'd3: address_shadow[7:0]   <= spi_rx_byte_i;
          3'd4: value_shadow[23:16]   <= spi_rx_byte_i;
          3'd5: value_shadow[15:8]    <= spi_rx_byte_i;
          3'd6: value_shadow[7:0]     <= spi_rx_byte_i;
          default: begin
            instruction_o <= opcode_shadow;
            address_o     <= address_shadow;
            value_o       <= {value_shadow, spi_rx_byte_i};
          end
        endcase
      end
    end
  end

  // Byte 0 of the reply is live so the host sees the freshest result word.
  always_comb begin
    spi_tx_byte_o = result_i[31:24];
    case (cnt)
      3'd1:    spi_tx_byte_o = tx_snapshot[55:48];
      3'd2:    spi_tx_byte_o = tx_snapshot[47:40];
      3'd3:    spi_tx_byte_o = tx_snapshot[39:32];
      3'd4:    spi_tx_byte_o = tx_snapshot[31:24];
      3'd5:    spi_tx_byte_o = tx_snapshot[23:16];
      3'd6:    spi_tx_byte_o = tx_snapshot[15:8];
      3'd7:    spi_tx_byte_o = tx_snapshot[7:0];
      default: spi_tx_byte_o = result_i[31:24];
    endcase
  end

endmodule

// File: tb/tb_instruction_handler.sv
// Bench for instruction_handler: directed frame table, hand-written corner sequences, randomized model check.
module tb_instruction_handler;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [7:0]  rx;
  logic [31:0] res;
  logic [31:0] strm;
  logic [7:0]  instruction_o;
  logic [23:0] address_o;
  logic [31:0] value_o;
  logic [7:0]  spi_tx_byte_o;

  always #5 clk = ~clk;

  instruction_handler dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .spi_rx_valid_i (vld),
    .spi_rx_byte_i  (rx),
    .result_i       (res),
    .stream_i       (strm),
    .instruction_o  (instruction_o),
    .address_o      (address_o),
    .value_o        (value_o),
    .spi_tx_byte_o  (spi_tx_byte_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] frame;
    bit          gaps;
    logic [7:0]  e_instr;
    logic [23:0] e_addr;
    logic [31:0] e_val;
  } vec_t;

  vec_t vecs[4];

  // Sends a frame starting at a negedge; returns at the negedge after the last byte.
  task automatic send_frame(input logic [63:0] f, input bit gaps,
                            input logic [23:0] prev_addr, input logic [31:0] prev_val);
    logic [63:0] fr;
    fr = f;
    for (int i = 0; i < 8; i++) begin
      vld = 1'b1;
      rx  = fr[63-8*i -: 8];
      @(negedge clk);
      vld = 1'b0;
      if (i < 7) begin
        chk("no_strobe_mid_frame", {56'h0, instruction_o}, {56'h0, 8'h00});
        chk("addr_hold_mid_frame", {40'h0, address_o}, {40'h0, prev_addr});
        chk("val_hold_mid_frame", {32'h0, value_o}, {32'h0, prev_val});
        if (gaps) @(negedge clk);
      end
    end
  endtask

  task automatic check_commit(input logic [7:0] ei, input logic [23:0] ea, input logic [31:0] ev);
    chk("commit_instr", {56'h0, instruction_o}, {56'h0, ei});
    chk("commit_addr", {40'h0, address_o}, {40'h0, ea});
    chk("commit_val", {32'h0, value_o}, {32'h0, ev});
    @(negedge clk);
    chk("strobe_clear", {56'h0, instruction_o}, {56'h0, 8'h00});
    chk("addr_held", {40'h0, address_o}, {40'h0, ea});
    chk("val_held", {32'h0, value_o}, {32'h0, ev});
  endtask

  // Reference model state: bytes received so far in the frame and the reply snapshot.
  int          m_n;
  logic [7:0]  m_bytes[8];
  logic [7:0]  m_reply[8];
  logic [7:0]  m_instr;
  logic [23:0] m_addr;
  logic [31:0] m_val;

  logic [23:0] prev_addr;
  logic [31:0] prev_val;
  logic [7:0]  tx_exp[7];
  logic [63:0] fr;
  bit          r_rst;

  initial begin
    rst  = 1'b1;
    vld  = 1'b0;
    rx   = 8'h00;
    res  = 32'h0;
    strm = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_instr", {56'h0, instruction_o}, 64'h0);
    chk("reset_addr", {40'h0, address_o}, 64'h0);
    chk("reset_val", {32'h0, value_o}, 64'h0);
    res = 32'hA1B2C3D4;
    #1;
    chk("idle_tx_live", {56'h0, spi_tx_byte_o}, {56'h0, 8'hA1});
    @(negedge clk);

    vecs[0] = '{64'h05123456_DEADBEEF, 1'b1, 8'h05, 24'h123456, 32'hDEADBEEF};
    vecs[1] = '{64'h05123456_DEADBEEF, 1'b0, 8'h05, 24'h123456, 32'hDEADBEEF};
    vecs[2] = '{64'h00ABCDEF_01020304, 1'b1, 8'h00, 24'hABCDEF, 32'h01020304};
    vecs[3] = '{64'hFF000000_FFFFFFFF, 1'b0, 8'hFF, 24'h000000, 32'hFFFFFFFF};
    prev_addr = 24'h0;
    prev_val  = 32'h0;
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].frame, vecs[v].gaps, prev_addr, prev_val);
      check_commit(vecs[v].e_instr, vecs[v].e_addr, vecs[v].e_val);
      prev_addr = vecs[v].e_addr;
      prev_val  = vecs[v].e_val;
    end

    // Reply snapshot taken at byte 0 must survive later changes to the core words.
    tx_exp[0] = 8'h22; tx_exp[1] = 8'h33; tx_exp[2] = 8'h44; tx_exp[3] = 8'h55;
    tx_exp[4] = 8'h66; tx_exp[5] = 8'h77; tx_exp[6] = 8'h88;
    fr   = 64'h01000010_00000020;
    res  = 32'h11223344;
    strm = 32'h55667788;
    for (int i = 0; i < 8; i++) begin
      vld = 1'b1;
      rx  = fr[63-8*i -: 8];
      @(negedge clk);
      vld  = 1'b0;
      res  = 32'h0;
      strm = 32'h0;
      #1;
      if (i < 7) chk("tx_snapshot_byte", {56'h0, spi_tx_byte_o}, {56'h0, tx_exp[i]});
      else       chk("tx_live_after_frame", {56'h0, spi_tx_byte_o}, 64'h0);
    end
    chk("tx_frame_commit_addr", {40'h0, address_o}, {40'h0, 24'h000010});

    // Reset mid-frame discards the partial frame.
    @(negedge clk);
    fr = 64'h09AAAAAA_BBBBBBBB;
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1;
      rx  = fr[63-8*i -: 8];
      @(negedge clk);
      vld = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_instr", {56'h0, instruction_o}, 64'h0);
    chk("midreset_addr", {40'h0, address_o}, 64'h0);
    chk("midreset_val", {32'h0, value_o}, 64'h0);
    res = 32'h5A000000;
    #1;
    chk("midreset_cnt0_tx", {56'h0, spi_tx_byte_o}, {56'h0, 8'h5A});
    @(negedge clk);
    send_frame(64'h07000001_00000002, 1'b1, 24'h0, 32'h0);
    check_commit(8'h07, 24'h000001, 32'h00000002);

    // Randomized traffic against the frame-level model.
    for (int c = 0; c < 3000; c++) begin
      r_rst = (c == 0) || ($urandom_range(0, 299) == 0);
      rst   = r_rst;
      vld   = ($urandom_range(0, 99) < 60);
      rx    = 8'($urandom);
      res   = $urandom;
      strm  = $urandom;
      if ($urandom_range(0, 9) == 0) rx = 8'h00;
      if (r_rst) begin
        m_n     = 0;
        m_instr = 8'h00;
        m_addr  = 24'h0;
        m_val   = 32'h0;
        for (int b = 0; b < 8; b++) begin
          m_bytes[b] = 8'h00;
          m_reply[b] = 8'h00;
        end
      end else begin
        m_instr = 8'h00;
        if (vld) begin
          m_bytes[m_n] = rx;
          if (m_n == 0) begin
            for (int b = 0; b < 4; b++) begin
              m_reply[b]   = res[31-8*b -: 8];
              m_reply[b+4] = strm[31-8*b -: 8];
            end
          end
          if (m_n == 7) begin
            m_instr = m_bytes[0];
            m_addr  = {m_bytes[1], m_bytes[2], m_bytes[3]};
            m_val   = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
          end
          m_n = (m_n + 1) % 8;
        end
      end
      @(negedge clk);
      chk("rand_instr", {56'h0, instruction_o}, {56'h0, m_instr});
      chk("rand_addr", {40'h0, address_o}, {40'h0, m_addr});
      chk("rand_val", {32'h0, value_o}, {32'h0, m_val});
      chk("rand_tx", {56'h0, spi_tx_byte_o},
          {56'h0, (m_n == 0) ? res[31:24] : m_reply[m_n]});
    end
    rst = 1'b0;
    vld = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_handler.md
Name: instruction_handler

Overview:
- Byte-level command decoder between an SPI slave byte interface and the core datapath.
- Assembles fixed 8-byte frames from received SPI bytes: 1 opcode byte, 3 address bytes, 4 value bytes.
- Commits each complete frame atomically to instruction/address/value outputs.
- Supplies the byte the SPI slave shifts out next, drawn from result_i and stream_i.

Parameters:
- None. Frame length is fixed at 8 bytes: 1 opcode, 3 address, 4 value, all MSB first.

Ports:
- clk_i  input  1  system clock; all logic on rising edge
- rst_i  input  1  synchronous active-high reset
- spi_rx_valid_i  input  1  one-cycle strobe; spi_rx_byte_i holds a received byte
- spi_rx_byte_i  input  8  received SPI byte
- result_i  input  32  core result word, returned to host
- stream_i  input  32  core stream/status word, returned to host
- instruction_o  output  8  committed opcode; nonzero for exactly one cycle per frame
- address_o  output  24  committed address; held between frames
- value_o  output  32  committed value; held between frames
- spi_tx_byte_o  output  8  byte the SPI slave transmits during the next byte transfer

Behaviour:
- One clock domain (clk_i). Reset is synchronous and active-high (rst_i).
- Reset values: byte counter 0, instruction_o 0x00, address_o 0, value_o 0, shadow registers 0, tx snapshot 0.
- Reset mid-frame discards the partial frame; no commit occurs.
- Byte counter cnt runs 0..7. It increments on every cycle with spi_rx_valid_i=1, including back-to-back cycles, and wraps 7->0. Cycles without valid change nothing.
- Byte placement by cnt at reception:
  - cnt=0: opcode shadow
  - cnt=1..3: address shadow [23:16], [15:8], [7:0]
  - cnt=4..7: value shadow [31:24], [23:16], [15:8], [7:0]
- Commit happens on the edge that accepts the byte at cnt=7. From the next cycle:
  - instruction_o = opcode shadow
  - address_o = full address shadow
  - value_o = shadow value with the just-received byte as [7:0]
- instruction_o returns to 0x00 one cycle after commit. It is a single-cycle execute strobe; 0x00 means NOP.
- A frame with opcode 0x00 still updates address_o and value_o, but instruction_o stays 0x00.
- address_o and value_o change only at commit. They never expose partial frames.
- TX path:
  - When cnt=0, spi_tx_byte_o = result_i[31:24], combinational live value.
  - On accepting the byte at cnt=0, snapshot {result_i, stream_i} in that same cycle.
  - When cnt=k for k=1..7, spi_tx_byte_o = snapshot byte k, MSB first: result[23:16], [15:8], [7:0], then stream[31:24], [23:16], [15:8], [7:0].
  - result_i and stream_i changes after the snapshot do not affect the current frame.
- Latency: 1 cycle from the last byte's valid strobe to the committed outputs. No backpressure; every valid byte is accepted.
- No other state machine states. Frame position is fully defined by cnt.

Test Plan:
- Reset then idle: instruction_o=0x00, address_o=0, value_o=0. Set result_i=0xA1B2C3D4 -> spi_tx_byte_o=0xA1.
- Send 0x05,0x12,0x34,0x56,0xDE,0xAD,0xBE,0xEF as single-cycle strobes with gaps -> next cycle instruction_o=0x05, address_o=0x123456, value_o=0xDEADBEEF; following cycle instruction_o=0x00, address/value held.
- Same frame sent on 8 consecutive valid cycles -> identical commit. Meanwhile address_o/value_o keep the prior frame's values until commit.
- result_i=0x11223344, stream_i=0x55667788 at byte 0; change both to 0 afterwards -> spi_tx_byte_o after bytes 1..7 = 0x22,0x33,0x44,0x55,0x66,0x77,0x88; after byte 8 -> live result_i[31:24]=0x00.
- Assert rst_i after 4 bytes, then send a full new frame 0x07,0x00,0x00,0x01,0x00,0x00,0x00,0x02 -> single commit: instruction_o=0x07, address_o=0x000001, value_o=0x00000002; no commit from the aborted bytes.
- Frame with opcode 0x00, address 0xABCDEF, value 0x01020304 -> address_o/value_o update, instruction_o never leaves 0x00.
